// File: rtl/dcache_ctrl_if.sv
// Pipeline (MA stage) and main-memory signals of the data cache, bundled as one bus.
// The slave view is the cache controller; the master view is the pipeline plus memory.
interface dcache_ctrl_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32
);
  logic                   req;
  logic                   we;
  logic [ADDR_SIZE-1:0]   addr;
  logic [DATA_SIZE-1:0]   wdata;
  logic [DATA_SIZE/8-1:0] be;
  logic                   flush;
  logic                   ready;
  logic [DATA_SIZE-1:0]   rdata;
  logic                   mem_req;
  logic                   mem_we;
  logic [ADDR_SIZE-1:0]   mem_addr;
  logic [DATA_SIZE-1:0]   mem_wdata;
  logic [DATA_SIZE/8-1:0] mem_be;
  logic                   mem_ack;
  logic [DATA_SIZE-1:0]   mem_rdata;

  modport slave (
    input  req, we, addr, wdata, be, flush, mem_ack, mem_rdata,
    output ready, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output req, we, addr, wdata, be, flush, mem_ack, mem_rdata,
    input  ready, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MA stage.
// Loads hit in zero cycles; misses refill a whole line word by word over a req/ack port.
//
// state      | meaning
// IDLE       | serving hits, launching refills/stores, flushing
// REFILL     | fetching line words from memory, one per ack
// STORE      | writing one word through to memory
// STORE_DONE | one-cycle ready pulse so the held store is not reissued
module dcache_ctrl #(
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_SIZE  = 32,
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input logic          i_clk,
  input logic          i_rst,
  dcache_ctrl_if.slave bus
);
  localparam int WB    = $clog2(LINE_WORDS);
  localparam int IB    = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_SIZE - 2 - WB - IB;
  localparam int NB    = DATA_SIZE / 8;
  localparam logic [WB-1:0] LAST = WB'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, STORE, STORE_DONE} state_t;

  state_t                 state;
  logic [NUM_LINES-1:0]   valid;
  logic [TAG_W-1:0]       tags [NUM_LINES];
  logic [DATA_SIZE-1:0]   data_mem [NUM_LINES*LINE_WORDS];
  logic [WB-1:0]          cnt;
  logic                   flush_pend;
  logic                   mem_req_q, mem_we_q;
  logic [ADDR_SIZE-1:0]   mem_addr_q;
  logic [DATA_SIZE-1:0]   mem_wdata_q;
  logic [NB-1:0]          mem_be_q;

  logic [WB-1:0]          a_word;
  logic [IB-1:0]          a_idx;
  logic [TAG_W-1:0]       a_tag;
  logic                   hit;
  logic [DATA_SIZE-1:0]   rd_word;
  logic                   data_we;
  logic [IB+WB-1:0]       data_waddr;
  logic [DATA_SIZE-1:0]   data_wdata;

  assign a_word  = bus.addr[2 +: WB];
  assign a_idx   = bus.addr[2+WB +: IB];
  assign a_tag   = bus.addr[ADDR_SIZE-1 -: TAG_W];
  assign hit     = valid[a_idx] && (tags[a_idx] == a_tag);
  assign rd_word = data_mem[{a_idx, a_word}];

  always_comb begin
    bus.ready = 1'b0;
    bus.rdata = '0;
    case (state)
      IDLE: begin
        bus.ready = !bus.flush && !(bus.req && (bus.we || !hit));
        if (bus.req && !bus.we && hit && !bus.flush) bus.rdata = rd_word;
      end
      STORE_DONE: bus.ready = 1'b1;
      default:    bus.ready = 1'b0;
    endcase
  end

  // Refill words come straight from memory; store hits merge into the cached word per byte enable.
  always_comb begin
    data_we    = 1'b0;
    data_waddr = {a_idx, cnt};
    data_wdata = bus.mem_rdata;
    if (!i_rst && state == REFILL && bus.mem_ack) begin
      data_we = 1'b1;
    end else if (!i_rst && state == STORE && bus.mem_ack && hit) begin
      data_we    = 1'b1;
      data_waddr = {a_idx, a_word};
      for (int b = 0; b < NB; b++)
        data_wdata[8*b +: 8] = mem_be_q[b] ? mem_wdata_q[8*b +: 8] : rd_word[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (data_we) data_mem[data_waddr] <= data_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      valid       <= '0;
      flush_pend  <= 1'b0;
      cnt         <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush) begin
            valid <= '0;
          end else if (bus.req && bus.we) begin
            state       <= STORE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {bus.addr[ADDR_SIZE-1:2], 2'b00};
            mem_wdata_q <= bus.wdata;
            mem_be_q    <= bus.be;
          end else if (bus.req && !hit) begin
            state      <= REFILL;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_be_q   <= '1;
            mem_addr_q <= {bus.addr[ADDR_SIZE-1:2+WB], {(WB+2){1'b0}}};
            cnt        <= '0;
          end
        end
        REFILL: begin
          if (bus.flush) flush_pend <= 1'b1;
          if (bus.mem_ack) begin
            if (cnt == LAST) begin
              state       <= IDLE;
              mem_req_q   <= 1'b0;
              tags[a_idx] <= a_tag;
              // A flush seen during the refill discards the freshly filled line too.
              if (bus.flush || flush_pend) begin
                valid      <= '0;
                flush_pend <= 1'b0;
              end else begin
                valid[a_idx] <= 1'b1;
              end
            end else begin
              cnt        <= cnt + 1'b1;
              mem_addr_q <= mem_addr_q + ADDR_SIZE'(4);
            end
          end
        end
        STORE: begin
          if (bus.flush) flush_pend <= 1'b1;
          if (bus.mem_ack) begin
            state     <= STORE_DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          if (bus.flush || flush_pend) begin
            valid      <= '0;
            flush_pend <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a word-wide memory responder with programmable ack delay
// and hand-computed expectations for hits, misses, stores, conflicts, flush and reset.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_ctrl_if #(.DATA_SIZE(32), .ADDR_SIZE(32)) bus ();

  dcache_ctrl #(.DATA_SIZE(32), .ADDR_SIZE(32), .NUM_LINES(16), .LINE_WORDS(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory image: untouched words read as {C0DE, low address half}.
  logic [31:0] tb_mem [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : {16'hC0DE, a[15:0]};
  endfunction

  int ack_delay = 2;
  int wait_cnt  = 0;
  int rd_cnt    = 0;
  int wr_cnt    = 0;
  int req_cyc   = 0;
  logic [31:0] rd_log [$];

  always @(negedge clk) begin
    logic [31:0] w;
    bus.mem_ack = 1'b0;
    if (bus.mem_req && !rst) begin
      req_cyc++;
      if (wait_cnt == ack_delay - 1) begin
        wait_cnt    = 0;
        bus.mem_ack = 1'b1;
        if (bus.mem_we) begin
          wr_cnt++;
          w = mem_rd(bus.mem_addr);
          for (int b = 0; b < 4; b++)
            if (bus.mem_be[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
          tb_mem[bus.mem_addr] = w;
        end else begin
          rd_cnt++;
          rd_log.push_back(bus.mem_addr);
          bus.mem_rdata = mem_rd(bus.mem_addr);
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Holds the request until ready; cyc counts stalled cycles seen before completion.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output int cyc,
                        output logic mreq_done);
    bit done;
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wd; bus.be = be;
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.ready) done = 1'b1;
      else begin
        cyc++;
        if (cyc > 400) done = 1'b1;
      end
    end
    if (cyc > 400) chk("access_timeout", 32'(cyc), 32'd0);
    rd        = bus.rdata;
    mreq_done = bus.mem_req;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  logic [31:0] rd;
  int          cyc;
  logic        mq;
  int          base_rd, base_wr, base_rq;

  initial begin
    rst = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    bus.flush = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: cold miss, four reads two cycles apart, then the held load hits
    base_rd = rd_cnt; base_rq = req_cyc;
    access(1'b0, 32'h100, '0, '0, rd, cyc, mq);
    chk("t1_cyc", 32'(cyc), 32'd9);
    chk("t1_rdata", rd, 32'hC0DE0100);
    chk("t1_reads", 32'(rd_cnt - base_rd), 32'd4);
    chk("t1_req_cyc", 32'(req_cyc - base_rq), 32'd8);
    chk("t1_addr0", rd_log[base_rd], 32'h100);
    chk("t1_addr1", rd_log[base_rd+1], 32'h104);
    chk("t1_addr2", rd_log[base_rd+2], 32'h108);
    chk("t1_addr3", rd_log[base_rd+3], 32'h10C);

    // 2: hit in the same line, no memory traffic
    base_rq = req_cyc;
    access(1'b0, 32'h108, '0, '0, rd, cyc, mq);
    chk("t2_cyc", 32'(cyc), 32'd0);
    chk("t2_rdata", rd, 32'hC0DE0108);
    chk("t2_req_cyc", 32'(req_cyc - base_rq), 32'd0);

    // 3: partial store hit, ack after 3 cycles
    ack_delay = 3;
    base_wr = wr_cnt; base_rq = req_cyc;
    access(1'b1, 32'h104, 32'hAAAA5555, 4'b0011, rd, cyc, mq);
    chk("t3_cyc", 32'(cyc), 32'd4);
    chk("t3_req_cyc", 32'(req_cyc - base_rq), 32'd3);
    chk("t3_done_mem_req", 32'(mq), 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_writes", 32'(wr_cnt - base_wr), 32'd1);
    chk("t3_mem_word", mem_rd(32'h104), 32'hC0DE5555);
    ack_delay = 2;
    access(1'b0, 32'h104, '0, '0, rd, cyc, mq);
    chk("t3_hit_cyc", 32'(cyc), 32'd0);
    chk("t3_hit_rdata", rd, 32'hC0DE5555);

    // 4: store miss is not allocated; resident line with same index survives
    base_wr = wr_cnt; base_rd = rd_cnt;
    access(1'b1, 32'h300, 32'h12345678, 4'b1111, rd, cyc, mq);
    chk("t4_writes", 32'(wr_cnt - base_wr), 32'd1);
    chk("t4_reads", 32'(rd_cnt - base_rd), 32'd0);
    access(1'b0, 32'h108, '0, '0, rd, cyc, mq);
    chk("t4_keep_cyc", 32'(cyc), 32'd0);
    base_rd = rd_cnt;
    access(1'b0, 32'h300, '0, '0, rd, cyc, mq);
    chk("t4_miss_cyc", 32'(cyc), 32'd9);
    chk("t4_rdata", rd, 32'h12345678);
    chk("t4_reads2", 32'(rd_cnt - base_rd), 32'd4);

    // 5: conflict misses on index 0
    access(1'b0, 32'h100, '0, '0, rd, cyc, mq);
    chk("t5_a_cyc", 32'(cyc), 32'd9);
    access(1'b0, 32'h200, '0, '0, rd, cyc, mq);
    chk("t5_b_cyc", 32'(cyc), 32'd9);
    chk("t5_b_rdata", rd, 32'hC0DE0200);
    base_rd = rd_cnt;
    access(1'b0, 32'h100, '0, '0, rd, cyc, mq);
    chk("t5_c_cyc", 32'(cyc), 32'd9);
    chk("t5_c_reads", 32'(rd_cnt - base_rd), 32'd4);
    chk("t5_c_last", rd_log[rd_log.size()-1], 32'h10C);
    access(1'b0, 32'h104, '0, '0, rd, cyc, mq);
    chk("t5_d_rdata", rd, 32'hC0DE5555);

    // 6a: flush during refill discards the line; held load refills again
    base_rd = rd_cnt;
    fork
      access(1'b0, 32'h200, '0, '0, rd, cyc, mq);
      begin
        for (int i = 0; i < 200 && rd_cnt < base_rd + 1; i++) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
      end
    join
    chk("t6a_cyc", 32'(cyc), 32'd18);
    chk("t6a_rdata", rd, 32'hC0DE0200);
    chk("t6a_reads", 32'(rd_cnt - base_rd), 32'd8);
    access(1'b0, 32'h100, '0, '0, rd, cyc, mq);
    chk("t6a_post_cyc", 32'(cyc), 32'd9);

    // flush in IDLE: not ready that cycle, line gone afterwards
    @(posedge clk); #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_ready", 32'(bus.ready), 32'd0);
    @(posedge clk); #1 bus.flush = 1'b0;
    access(1'b0, 32'h100, '0, '0, rd, cyc, mq);
    chk("idle_flush_cyc", 32'(cyc), 32'd9);

    // 6b: reset after two refill acks
    base_rd = rd_cnt;
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h400;
    for (int i = 0; i < 200 && rd_cnt < base_rd + 2; i++) @(posedge clk);
    #1 rst = 1'b1; bus.req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6b_mem_req", 32'(bus.mem_req), 32'd0);
    chk("t6b_ready", 32'(bus.ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("t6b_reads", 32'(rd_cnt - base_rd), 32'd2);
    access(1'b0, 32'h100, '0, '0, rd, cyc, mq);
    chk("t6b_post_cyc", 32'(cyc), 32'd9);
    chk("t6b_post_rdata", rd, 32'hC0DE0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
